// File: rtl/seven_segment_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scan_reader_pkg
//  Description : Shared seven-segment constants. Patterns are GFEDCBA,
//                with segment a in bit 0 and segment g in bit 6.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_scan_reader_pkg;

    localparam int SEG_WIDTH    = 7;
    localparam int NIBBLE_WIDTH = 4;

    localparam logic [SEG_WIDTH-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_WIDTH-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_WIDTH-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_WIDTH-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_WIDTH-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_WIDTH-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_WIDTH-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_WIDTH-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_WIDTH-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_WIDTH-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_WIDTH-1:0] SEG_A = 7'h77;
    localparam logic [SEG_WIDTH-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_WIDTH-1:0] SEG_C = 7'h39;
    localparam logic [SEG_WIDTH-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_WIDTH-1:0] SEG_E = 7'h79;
    localparam logic [SEG_WIDTH-1:0] SEG_F = 7'h71;

endpackage
`default_nettype wire

// File: rtl/seven_segment_pattern_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_pattern_decoder
//  Description : Combinational inverse of the hex-to-segment encoder. Any
//                pattern that is not one of the 16 hex glyphs yields nibble 0
//                with the invalid flag raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_pattern_decoder
    import seven_segment_scan_reader_pkg::*;
(
    input  logic [SEG_WIDTH-1:0]    pattern,
    output logic [NIBBLE_WIDTH-1:0] nibble,
    output logic                    invalid
);

    // Map each glyph back to its nibble; everything else is flagged.
    always_comb begin
        nibble  = '0;
        invalid = 1'b0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scan_reader
//  Description : Recovers the hex digits shown on a multiplexed seven-segment
//                display and presents each complete frame on a valid/ready
//                output. Inputs are asynchronous and are synchronised first.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scan_reader
    import seven_segment_scan_reader_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int SETTLE_CYCLES   = 16,
    parameter bit SEG_ACTIVE_HIGH = 1'b1,
    parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
    input  logic                               CLK_IN,
    input  logic                               RESET_IN,
    input  logic [NUM_DIGITS-1:0]              DIGIT_SEL_IN,
    input  logic [SEG_WIDTH-1:0]               SEGMENTS_IN,
    output logic [NIBBLE_WIDTH*NUM_DIGITS-1:0] VALUE_OUT,
    output logic [NUM_DIGITS-1:0]              INVALID_OUT,
    output logic                               VLD_OUT,
    input  logic                               RDY_IN,
    output logic                               OVERRUN_OUT
);

    localparam int                 c_cnt_w    = $clog2(SETTLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_hold   = 2'd2;

    logic [NUM_DIGITS-1:0]              w_sel_norm;
    logic [SEG_WIDTH-1:0]               w_seg_norm;
    logic [NUM_DIGITS-1:0]              r_sel_s1, r_sel_s2, r_sel_prev;
    logic [SEG_WIDTH-1:0]               r_seg_s1, r_seg_s2, r_seg_prev;
    logic                               w_sel_chg, w_seg_chg, w_onehot;
    logic                               w_sample, w_mask_full;
    logic [1:0]                         r_state;
    logic [c_cnt_w-1:0]                 r_cnt;
    logic [NIBBLE_WIDTH-1:0]            w_nibble;
    logic                               w_invalid;
    logic [NIBBLE_WIDTH*NUM_DIGITS-1:0] r_work_val, r_value;
    logic [NUM_DIGITS-1:0]              r_work_inv, r_invalid, r_mask;
    logic                               r_vld, r_overrun;

    // Normalise polarity so everything downstream is active-high.
    assign w_sel_norm = DIG_ACTIVE_HIGH ? DIGIT_SEL_IN : ~DIGIT_SEL_IN;
    assign w_seg_norm = SEG_ACTIVE_HIGH ? SEGMENTS_IN  : ~SEGMENTS_IN;

    // Two-flop synchroniser plus a one-cycle history copy for change detection.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_sel_s1   <= '0;
            r_sel_s2   <= '0;
            r_sel_prev <= '0;
            r_seg_s1   <= '0;
            r_seg_s2   <= '0;
            r_seg_prev <= '0;
        end else begin
            r_sel_s1   <= w_sel_norm;
            r_sel_s2   <= r_sel_s1;
            r_sel_prev <= r_sel_s2;
            r_seg_s1   <= w_seg_norm;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
        end
    end

    assign w_sel_chg   = (r_sel_s2 != r_sel_prev);
    assign w_seg_chg   = (r_seg_s2 != r_seg_prev);
    assign w_onehot    = $onehot(r_sel_s2);
    assign w_sample    = (r_state == c_st_settle) && w_onehot && !w_sel_chg &&
                         !w_seg_chg && (r_cnt == c_cnt_last);
    assign w_mask_full = &r_mask;

    // Settle/hold sequencer: one sample per strobe once the inputs have been quiet long enough.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                    if (w_onehot) r_state <= c_st_settle;
                end
                c_st_settle: begin
                    if (!w_onehot) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (w_sel_chg || w_seg_chg) begin
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_hold;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                c_st_hold: begin
                    r_cnt <= '0;
                    // Segment-only changes are ignored here so a strobe is read once.
                    if (!w_onehot)      r_state <= c_st_idle;
                    else if (w_sel_chg) r_state <= c_st_settle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    seven_segment_pattern_decoder u_decoder (
        .pattern (r_seg_s2),
        .nibble  (w_nibble),
        .invalid (w_invalid)
    );

    // Working frame: the strobed digit's slot is (over)written on each sample; a full mask empties it.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_work_val <= '0;
            r_work_inv <= '0;
            r_mask     <= '0;
        end else begin
            if (w_mask_full) r_mask <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_sample && r_sel_s2[i]) begin
                    r_work_val[i*NIBBLE_WIDTH +: NIBBLE_WIDTH] <= w_nibble;
                    r_work_inv[i]                              <= w_invalid;
                    r_mask[i]                                  <= 1'b1;
                end
            end
        end
    end

    // Output stage: publish a complete frame if the slot is free or being drained, else flag overrun.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_value   <= '0;
            r_invalid <= '0;
            r_vld     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_mask_full) begin
            if (!r_vld || RDY_IN) begin
                r_value   <= r_work_val;
                r_invalid <= r_work_inv;
                r_vld     <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_vld && RDY_IN) begin
            r_vld <= 1'b0;
        end
    end

    assign VALUE_OUT   = r_value;
    assign INVALID_OUT = r_invalid;
    assign VLD_OUT     = r_vld;
    assign OVERRUN_OUT = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_scan_reader
//  Description : Self-checking bench with a digit-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_reader;

    localparam int ND = 4;

    typedef struct packed {
        logic [ND-1:0]   inv;
        logic [4*ND-1:0] val;
    } frame_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ND-1:0]   sel;
    logic [6:0]      seg;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   invalid;
    logic            vld;
    logic            rdy;
    logic            overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seven_segment_scan_reader #(
        .NUM_DIGITS      (ND),
        .SETTLE_CYCLES   (16),
        .SEG_ACTIVE_HIGH (1'b1),
        .DIG_ACTIVE_HIGH (1'b1)
    ) dut (
        .CLK_IN       (clk),
        .RESET_IN     (rst_n),
        .DIGIT_SEL_IN (sel),
        .SEGMENTS_IN  (seg),
        .VALUE_OUT    (value),
        .INVALID_OUT  (invalid),
        .VLD_OUT      (vld),
        .RDY_IN       (rdy),
        .OVERRUN_OUT  (overrun)
    );

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] m_nib  [ND];
    logic       m_inv  [ND];
    bit         m_have [ND];
    frame_t     exp_q[$];

    // Returns {invalid, nibble} by searching the glyph table.
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++)
            if (glyph[k] == p) return {1'b0, 4'(k)};
        return 5'h10;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ND; i++) m_have[i] = 1'b0;
    endfunction

    function automatic void model_capture(input int d, input logic [6:0] p);
        logic [4:0] r;
        bit         full;
        frame_t     f;
        r         = ref_decode(p);
        m_nib[d]  = r[3:0];
        m_inv[d]  = r[4];
        m_have[d] = 1'b1;
        full = 1'b1;
        for (int i = 0; i < ND; i++) full &= m_have[i];
        if (full) begin
            f = '0;
            for (int i = 0; i < ND; i++) begin
                f.val = f.val | ((4*ND)'(m_nib[i]) << (4*i));
                f.inv[i] = m_inv[i];
            end
            exp_q.push_back(f);
            model_clear();
        end
    endfunction

    // ---------------- output monitor ----------------
    bit     mon_en      = 1'b0;
    bit     prev_vld    = 1'b0;
    int     frames_seen = 0;
    frame_t last_f      = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_vld) begin
                chk_val("vld_drop", vld, 1'b0);
            end else if (vld) begin
                frames_seen++;
                last_f = {invalid, value};
                if (exp_q.size() == 0) chk_val("frame_expected", exp_q.size(), 1);
                else                   chk_val("frame", {invalid, value}, exp_q.pop_front());
            end
            prev_vld = vld && rdy;
        end else begin
            prev_vld = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic blank(input int n);
        sel = '0;
        for (int c = 0; c < n; c++) begin
            seg = 7'($urandom);
            tick();
        end
    endtask

    task automatic scan_digit(input int d, input logic [6:0] pat, input bit glitch,
                              input logic [6:0] gpat, input bit tail, input logic [6:0] tpat);
        model_capture(d, pat);
        for (int c = 0; c < 40; c++) begin
            sel    = '0;
            sel[d] = 1'b1;
            if (glitch && c >= 5 && c < 8) seg = gpat;
            else if (tail && c >= 35)      seg = tpat;
            else                           seg = pat;
            tick();
        end
        blank(3);
    endtask

    task automatic ghost();
        int a, b;
        a = $urandom_range(ND-1);
        b = (a + 1 + $urandom_range(ND-2)) % ND;
        for (int c = 0; c < 20; c++) begin
            sel    = '0;
            sel[a] = 1'b1;
            sel[b] = 1'b1;
            seg    = 7'($urandom);
            tick();
        end
        blank(3);
    endtask

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(3) != 0) return glyph[$urandom_range(15)];
        return 7'($urandom);
    endfunction

    task automatic scan_all_random();
        for (int d = 0; d < ND; d++) scan_digit(d, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_t f1;
        int     seen0;
        rst_n = 1'b0;
        rdy   = 1'b1;
        sel   = '0;
        seg   = '0;
        model_clear();

        // Reset with inputs toggling: every output stays at zero.
        for (int c = 0; c < 10; c++) begin
            sel = ND'($urandom);
            seg = 7'($urandom);
            tick();
            chk_val("reset_outs", {overrun, vld, invalid, value}, 0);
        end
        sel   = '0;
        seg   = '0;
        rst_n = 1'b1;
        blank(3);
        mon_en = 1'b1;

        // Basic scan 3F,4F,7C,71.
        scan_digit(0, 7'h3F, 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(1, 7'h4F, 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(2, 7'h7C, 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(3, 7'h71, 1'b0, 7'h00, 1'b0, 7'h00);
        chk_val("basic_frame", last_f, {4'b0000, 16'hFB30});
        chk_val("basic_count", frames_seen, 1);

        // Glitch on digit 1 plus a non-glyph on digit 2.
        scan_digit(0, 7'h06, 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(1, 7'h5B, 1'b1, 7'h7F, 1'b0, 7'h00);
        scan_digit(2, 7'h49, 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(3, 7'h66, 1'b0, 7'h00, 1'b1, 7'h7F);
        chk_val("glitch_invalid_frame", last_f, {4'b0100, 16'h4021});
        chk_val("glitch_count", frames_seen, 2);

        // Ghosted strobes never sample; the frame completes only after a clean digit 3.
        scan_digit(0, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(1, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(2, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        ghost();
        ghost();
        chk_val("ghost_noframe", frames_seen, 2);
        scan_digit(3, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        chk_val("ghost_then_clean", frames_seen, 3);

        // Randomised scanning in arbitrary digit order.
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(9) == 0) ghost();
            else scan_digit($urandom_range(ND-1), rand_pat(), 1'($urandom_range(1)),
                            7'($urandom), 1'($urandom_range(1)), 7'($urandom));
        end
        chk_val("frames_left", exp_q.size(), 0);

        // Reset mid-frame discards the partial capture.
        scan_digit(0, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(1, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(2, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        sel    = 4'b0001;
        tick();
        tick();
        chk_val("midreset_outs", {overrun, vld, invalid, value}, 0);
        sel   = '0;
        rst_n = 1'b1;
        model_clear();
        blank(3);
        mon_en = 1'b1;
        seen0  = frames_seen;
        scan_digit(3, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        chk_val("midreset_partial", frames_seen, seen0);
        scan_digit(0, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(1, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        scan_digit(2, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
        chk_val("midreset_frame", frames_seen, seen0 + 1);

        // Back-pressure: first frame held, second dropped, overrun sticky.
        mon_en = 1'b0;
        rdy    = 1'b0;
        scan_all_random();
        chk_val("bp_vld1", vld, 1'b1);
        chk_val("bp_overrun_clear", overrun, 1'b0);
        f1 = exp_q.pop_front();
        chk_val("bp_first", {invalid, value}, f1);
        for (int d = 0; d < ND; d++) begin
            scan_digit(d, rand_pat(), 1'b0, 7'h00, 1'b0, 7'h00);
            chk_val("bp_hold", {invalid, value}, f1);
        end
        void'(exp_q.pop_front());
        chk_val("bp_overrun", overrun, 1'b1);
        chk_val("bp_vld2", vld, 1'b1);
        rdy = 1'b1;
        tick();
        chk_val("bp_accept_vld", vld, 1'b0);
        blank(5);
        chk_val("bp_overrun_sticky", overrun, 1'b1);
        chk_val("bp_vld_stays_low", vld, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
